imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_byte_packer.sv | 36 +++
 rtl/imem_loader.sv | 197 +++++++++++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

    localparam int unsigned IMEM_DEPTH     = 64;
    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned COUNT_W        = HDR_BYTES * BYTE_W;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR_HI  = 3'd1,
        S_HDR_LO  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4,
        S_DONE    = 3'd5
    } loader_state_t;

    // True when a header word count cannot fit in a memory of the given depth.
    function automatic logic count_exceeds(input logic [COUNT_W-1:0] n, input int unsigned depth);
        return 32'(n) > depth;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs big-endian bytes into words: the first byte of a word lands in the MSBs.
module byte_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_byte_en,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word_c,
    output logic              o_word_valid_c
);

    localparam int unsigned IDX_W   = $clog2(BYTES_PER_WORD);
    localparam int unsigned SHIFT_W = (BYTES_PER_WORD - 1) * BYTE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [SHIFT_W-1:0] r_shift;
    logic [IDX_W-1:0]   r_idx;

    // The word completes on the byte that arrives while the index is at its last slot.
    assign o_word_valid_c = i_byte_en && (r_idx == LAST_IDX);
    assign o_word_c       = {r_shift, i_byte};

    // Shift in each accepted byte; a clear or reset drops any partial word.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_byte_en) begin
            r_shift <= {r_shift[SHIFT_W-BYTE_W-1:0], i_byte};
            r_idx   <= r_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a program image from a byte stream into the instruction memory write port,
// holding the CPU in reset while the load runs.
// Optional trailer checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter  int unsigned DEPTH = IMEM_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          cpu_hold,
    output logic          done,
    output logic [AW:0]   word_count,
    output logic          err_overflow,
    output logic          csum_err
);

    localparam int unsigned CW = AW + 1;

`ifdef IMEM_LOADER_CSUM_EN
    localparam loader_state_t AFTER_PAYLOAD = S_CSUM;
`else
    localparam loader_state_t AFTER_PAYLOAD = S_DONE;
`endif

    loader_state_t      r_state;
    loader_state_t      w_state_nxt;

    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_word_idx;
    logic               r_finish;
    logic               r_wr_en;
    logic [AW-1:0]      r_wr_addr;
    logic [WORD_W-1:0]  r_wr_data;
    logic               r_cpu_hold;
    logic               r_done;
    logic [AW:0]        r_word_count;
    logic               r_err_overflow;

    logic               w_byte_ready;
    logic               w_accept;
    logic               w_start;
    logic               w_pay_accept;
    logic [COUNT_W-1:0] w_hdr_n;
    logic [WORD_W-1:0]  w_word;
    logic               w_word_valid;
    logic               w_last_word;
    logic               w_finish;

    // Handshake and decode terms; byte_ready depends on state alone.
    assign w_byte_ready = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) ||
                          (r_state == S_PAYLOAD) || (r_state == S_CSUM);
    assign w_accept     = byte_valid && w_byte_ready;
    assign w_start      = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_pay_accept = w_accept && (r_state == S_PAYLOAD);
    assign w_hdr_n      = {r_count[COUNT_W-1:BYTE_W], byte_data};
    assign w_last_word  = w_word_valid && (r_word_idx == (r_count - COUNT_W'(1)));
    assign w_finish     = (w_state_nxt == S_DONE) && (r_state != S_DONE);

    byte_packer u_packer (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_clear        (w_start),
        .i_byte_en      (w_pay_accept),
        .i_byte         (byte_data),
        .o_word_c       (w_word),
        .o_word_valid_c (w_word_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the frame parser.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_nxt = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (w_accept) w_state_nxt = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (w_accept) begin
                    if (w_hdr_n == '0) w_state_nxt = AFTER_PAYLOAD;
                    else               w_state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_last_word) w_state_nxt = AFTER_PAYLOAD;
            end
            S_CSUM: begin
                if (w_accept) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Header capture, write port, counters and completion flags.
    // done and the CPU release trail entry into DONE by one cycle so the last write lands first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count        <= '0;
            r_word_idx     <= '0;
            r_finish       <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_cpu_hold     <= 1'b0;
            r_done         <= 1'b0;
            r_word_count   <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            r_wr_en  <= 1'b0;
            r_finish <= w_finish;

            if (w_start) begin
                r_count        <= '0;
                r_word_idx     <= '0;
                r_done         <= 1'b0;
                r_word_count   <= '0;
                r_err_overflow <= 1'b0;
                r_cpu_hold     <= 1'b1;
            end else if (r_finish) begin
                r_done     <= 1'b1;
                r_cpu_hold <= 1'b0;
            end

            if (w_accept && (r_state == S_HDR_HI)) begin
                r_count[COUNT_W-1:BYTE_W] <= byte_data;
            end

            if (w_accept && (r_state == S_HDR_LO)) begin
                r_count[BYTE_W-1:0] <= byte_data;
                if (count_exceeds(w_hdr_n, DEPTH)) r_err_overflow <= 1'b1;
            end

            // Words beyond the memory are consumed but never written.
            if (w_word_valid) begin
                r_word_idx <= r_word_idx + COUNT_W'(1);
                if (32'(r_word_idx) < DEPTH) begin
                    r_wr_en      <= 1'b1;
                    r_wr_addr    <= AW'(r_word_idx);
                    r_wr_data    <= w_word;
                    r_word_count <= r_word_count + CW'(1);
                end
            end
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    logic [BYTE_W-1:0] r_csum;
    logic              r_csum_err;

    // Running XOR of payload bytes, compared against the trailer byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_csum     <= '0;
            r_csum_err <= 1'b0;
        end else if (w_start) begin
            r_csum     <= '0;
            r_csum_err <= 1'b0;
        end else begin
            if (w_pay_accept) r_csum <= r_csum ^ byte_data;
            if (w_accept && (r_state == S_CSUM) && (byte_data != r_csum)) r_csum_err <= 1'b1;
        end
    end

    assign csum_err = r_csum_err;
`else
    assign csum_err = 1'b0;
`endif

    assign byte_ready   = w_byte_ready;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign cpu_hold     = r_cpu_hold;
    assign done         = r_done;
    assign word_count   = r_word_count;
    assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; define IMEM_LOADER_CSUM_EN to cover the trailer byte.
module tb_imem_loader;

    localparam int unsigned AW = 6;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_hold;
    logic          done;
    logic [AW:0]   word_count;
    logic          err_overflow;
    logic          csum_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [AW-1:0] log_addr [0:511];
    logic [31:0]   log_data [0:511];
    int            n_wr = 0;

    imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .word_count   (word_count),
        .err_overflow (err_overflow),
        .csum_err     (csum_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write seen on the port.
    always @(negedge clk) begin
        if (wr_en && n_wr < 512) begin
            log_addr[n_wr] = wr_addr;
            log_data[n_wr] = wr_data;
            n_wr = n_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte from a negedge and return at the negedge after it is taken.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard      = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Two-word frame: expects 0x20100001 at 0 and 0x00102020 at 1 (payload XOR is 0x21).
    task automatic run_two_word(input string tag, input int max_gap, input bit inject_start,
                                input bit bad_csum);
        logic [7:0] fr [10];
        logic       exp_ce;
        int         base;
        fr     = '{8'h00, 8'h02, 8'h20, 8'h10, 8'h00, 8'h01, 8'h00, 8'h10, 8'h20, 8'h20};
        exp_ce = 1'b0;
        base   = n_wr;
        do_start();
        chk({tag, "_hold_on"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_ovf_clr"}, 32'(err_overflow), 32'd0);
        for (int i = 0; i < 10; i++) begin
            idle($urandom_range(max_gap, 0));
            if (inject_start && i == 4) begin
                do_start();
                chk({tag, "_ign_start_hold"}, 32'(cpu_hold), 32'd1);
                chk({tag, "_ign_start_ready"}, 32'(byte_ready), 32'd1);
            end
            send_byte(fr[i]);
        end
`ifdef IMEM_LOADER_CSUM_EN
        idle($urandom_range(max_gap, 0));
        exp_ce = bad_csum;
        send_byte(bad_csum ? 8'h00 : 8'h21);
`endif
        chk({tag, "_done_k1"}, 32'(done), 32'd0);
        chk({tag, "_hold_k1"}, 32'(cpu_hold), 32'd1);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_hold_off"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_ready_off"}, 32'(byte_ready), 32'd0);
        chk({tag, "_wcount"}, 32'(word_count), 32'd2);
        chk({tag, "_csum_err"}, 32'(csum_err), 32'(exp_ce));
        chk({tag, "_nwrites"}, 32'(n_wr - base), 32'd2);
        chk({tag, "_addr0"}, 32'(log_addr[base]), 32'd0);
        chk({tag, "_data0"}, log_data[base], 32'h2010_0001);
        chk({tag, "_addr1"}, 32'(log_addr[base + 1]), 32'd1);
        chk({tag, "_data1"}, log_data[base + 1], 32'h0010_2020);
    endtask

    initial begin
        int base;
        int bad;
        logic [31:0] exp_w;

        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        idle(3);

        // Reset values
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_err_overflow", 32'(err_overflow), 32'd0);
        chk("rst_csum_err", 32'(csum_err), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Back-to-back two-word load
        run_two_word("two", 0, 1'b0, 1'b0);

        // Empty load: header only
        base = n_wr;
        do_start();
        chk("empty_wcount_clr", 32'(word_count), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'h00);
`endif
        chk("empty_done_k1", 32'(done), 32'd0);
        @(negedge clk);
        chk("empty_done_k2", 32'(done), 32'd1);
        chk("empty_hold_off", 32'(cpu_hold), 32'd0);
        chk("empty_wcount", 32'(word_count), 32'd0);
        chk("empty_csum_err", 32'(csum_err), 32'd0);
        idle(2);
        chk("empty_nwrites", 32'(n_wr - base), 32'd0);

        // Overflow: 65 words into a 64-word memory; byte j of word w is 4w+j
        base = n_wr;
        do_start();
        send_byte(8'h00);
        send_byte(8'h41);
        chk("ovf_flag_early", 32'(err_overflow), 32'd1);
        for (int w = 0; w < 65; w++) begin
            for (int j = 0; j < 4; j++) send_byte(8'(4 * w + j));
        end
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'h00);
`endif
        @(negedge clk);
        chk("ovf_done", 32'(done), 32'd1);
        chk("ovf_hold_off", 32'(cpu_hold), 32'd0);
        chk("ovf_flag", 32'(err_overflow), 32'd1);
        chk("ovf_wcount", 32'(word_count), 32'd64);
        chk("ovf_csum_err", 32'(csum_err), 32'd0);
        chk("ovf_nwrites", 32'(n_wr - base), 32'd64);
        chk("ovf_data0", log_data[base], 32'h0001_0203);
        chk("ovf_addr63", 32'(log_addr[base + 63]), 32'd63);
        chk("ovf_data63", log_data[base + 63], 32'hFCFD_FEFF);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            exp_w = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
            if (log_addr[base + i] !== AW'(i) || log_data[base + i] !== exp_w) bad++;
        end
        chk("ovf_seq_bad", 32'(bad), 32'd0);

        // Random gaps plus a start pulse mid-payload; overflow flag cleared by start
        run_two_word("gap", 3, 1'b1, 1'b0);

        // Reset after two payload bytes of a one-word frame
        base = n_wr;
        do_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_ready", 32'(byte_ready), 32'd0);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        idle(3);
        chk("mid_rst_nwrites", 32'(n_wr - base), 32'd0);

        // A fresh load after reset starts on a clean word boundary
        run_two_word("post_rst", 1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CSUM_EN
        // Wrong trailer: words still written, done still set
        run_two_word("bad_csum", 0, 1'b0, 1'b1);
        run_two_word("good_csum", 0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
